// File: rtl/mem_dump_reader.sv
// -----------------------------------------------------------------------------
// mem_dump_reader
//
// Walks the data memory from address 0 to N_ADDRESS-1 through its asynchronous
// read port and serializes every word, least significant byte first, onto a
// valid/ready byte stream that feeds the debug UART transmitter. Used after
// program halt to ship the memory image to the host.
//
// Optional feature: define MEM_DUMP_HEADER_EN to prefix the dump with a
// two-byte header (8'hA5, then the word count) before the first word.
//
// Per-word sequence with the stream always ready:
//   READ (1 cycle, word latched) -> SEND (NB_DATA/8 cycles, one byte each)
// so each word costs 1 + NB_DATA/8 cycles, and DONE follows the last byte.
// -----------------------------------------------------------------------------
module mem_dump_reader #(
    parameter int NB_DATA    = 32,
    parameter int N_ADDRESS  = 64,
    parameter int NB_ADDRESS = $clog2(N_ADDRESS),
    parameter int NB_BYTE    = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic [NB_ADDRESS-1:0] o_r_addr,
    output logic                  o_r_en,
    input  logic [NB_DATA-1:0]    i_r_data,
    output logic [NB_BYTE-1:0]    o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    // Bytes per memory word and the width of the counter that walks them.
    // NB_DATA is expected to be a whole number of bytes.
    localparam int N_BYTES = NB_DATA / NB_BYTE;
    localparam int NB_BCNT = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    localparam logic [NB_ADDRESS-1:0] LAST_ADDR = NB_ADDRESS'(N_ADDRESS - 1);
    localparam logic [NB_BCNT-1:0]    LAST_BYTE = NB_BCNT'(N_BYTES - 1);

`ifdef MEM_DUMP_HEADER_EN
    // Header bytes sent ahead of the first word.
    localparam logic [NB_BYTE-1:0] HDR_MAGIC = NB_BYTE'(8'hA5);
    localparam logic [NB_BYTE-1:0] HDR_COUNT = NB_BYTE'(N_ADDRESS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_SEND,
        ST_DONE,
        ST_HDR
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_SEND,
        ST_DONE
    } state_t;
`endif

    state_t                state;
    logic [NB_ADDRESS-1:0] addr;      // word currently being dumped
    logic [NB_BCNT-1:0]    byte_cnt;  // byte of the word on the stream
    logic [NB_DATA-1:0]    word_q;    // word captured in READ

    // A byte leaves the block on any edge where both sides agree.
    logic tx_fire;
    assign tx_fire = o_tx_valid && i_tx_ready;

    // The read address is the word counter itself; it only changes at dump
    // start and when advancing to the next word, so it holds elsewhere.
    assign o_r_addr = addr;

    // Selects byte idx of a word, byte 0 being the least significant.
    function automatic logic [NB_BYTE-1:0] pick_byte(
        input logic [NB_DATA-1:0] word,
        input logic [NB_BCNT-1:0] idx
    );
        logic [NB_DATA-1:0] shifted;
        shifted = word >> (int'(idx) * NB_BYTE);
        return shifted[NB_BYTE-1:0];
    endfunction

    // Dump sequencer: state, counters, captured word and all registered outputs.
    // NOTE: every sequential assignment here is non-blocking so all registers
    // update together from pre-edge values; a blocking write would let later
    // lines in this block see a half-updated state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            addr       <= '0;
            byte_cnt   <= '0;
            word_q     <= '0;
            o_r_en     <= 1'b0;
            o_tx_data  <= '0;
            o_tx_valid <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            // NOTE: the default arm returns an illegal encoding to IDLE, so no
            // state value can leave the sequencer stuck.
            unique case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        addr     <= '0;
                        byte_cnt <= '0;
                        o_busy   <= 1'b1;
`ifdef MEM_DUMP_HEADER_EN
                        state      <= ST_HDR;
                        o_tx_valid <= 1'b1;
                        o_tx_data  <= HDR_MAGIC;
`else
                        state  <= ST_READ;
                        o_r_en <= 1'b1;
`endif
                    end
                end

`ifdef MEM_DUMP_HEADER_EN
                ST_HDR: begin
                    if (tx_fire) begin
                        if (byte_cnt == '0) begin
                            byte_cnt  <= NB_BCNT'(1);
                            o_tx_data <= HDR_COUNT;
                        end else begin
                            // Header complete: the dump proper starts at word 0.
                            byte_cnt   <= '0;
                            o_tx_valid <= 1'b0;
                            o_r_en     <= 1'b1;
                            state      <= ST_READ;
                        end
                    end
                end
`endif

                ST_READ: begin
                    // Read data is combinational from the address, so it is
                    // captured at the end of this single cycle. Byte 0 is
                    // presented straight from the read port to save a cycle.
                    word_q     <= i_r_data;
                    byte_cnt   <= '0;
                    o_r_en     <= 1'b0;
                    o_tx_valid <= 1'b1;
                    o_tx_data  <= i_r_data[NB_BYTE-1:0];
                    state      <= ST_SEND;
                end

                ST_SEND: begin
                    // Without a handshake nothing changes, so the presented
                    // byte is held until it is taken.
                    if (tx_fire) begin
                        if (byte_cnt != LAST_BYTE) begin
                            byte_cnt  <= byte_cnt + 1'b1;
                            o_tx_data <= pick_byte(word_q, byte_cnt + 1'b1);
                        end else if (addr != LAST_ADDR) begin
                            addr       <= addr + 1'b1;
                            o_tx_valid <= 1'b0;
                            o_r_en     <= 1'b1;
                            state      <= ST_READ;
                        end else begin
                            // Last byte of the last word: the counter stops
                            // here rather than wrapping.
                            o_tx_valid <= 1'b0;
                            o_done     <= 1'b1;
                            state      <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end

                default: begin
                    state      <= ST_IDLE;
                    o_r_en     <= 1'b0;
                    o_tx_valid <= 1'b0;
                    o_busy     <= 1'b0;
                    o_done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump_reader.sv
// -----------------------------------------------------------------------------
// tb_mem_dump_reader
//
// Scoreboard bench: starting a dump pushes the expected byte stream (computed
// directly from the memory image) into a queue, and an independent monitor
// pops and compares on every accepted byte. Directed cycle checks cover the
// reset state, first-word timing, backpressure, restart attempts, mid-dump
// reset and completion timing; random images and random backpressure follow.
// Honours MEM_DUMP_HEADER_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_mem_dump_reader;

    localparam int NB_DATA    = 32;
    localparam int N_ADDRESS  = 64;
    localparam int NB_ADDRESS = $clog2(N_ADDRESS);
    localparam int NB_BYTE    = 8;
    localparam int N_BYTES    = NB_DATA / NB_BYTE;

`ifdef MEM_DUMP_HEADER_EN
    localparam int H = 2;
`else
    localparam int H = 0;
`endif
    // With the stream always ready each word costs 1 + N_BYTES cycles.
    localparam int DONE_CYC = (1 + N_BYTES) * N_ADDRESS + 1 + H;

    logic                  i_clk      = 1'b0;
    logic                  i_rst      = 1'b1;
    logic                  i_start    = 1'b0;
    logic                  i_tx_ready = 1'b0;
    logic [NB_ADDRESS-1:0] o_r_addr;
    logic                  o_r_en;
    logic [NB_DATA-1:0]    i_r_data;
    logic [NB_BYTE-1:0]    o_tx_data;
    logic                  o_tx_valid;
    logic                  o_busy;
    logic                  o_done;

    // Memory model: asynchronous read port.
    logic [NB_DATA-1:0] mem [N_ADDRESS];
    assign i_r_data = mem[o_r_addr];

    mem_dump_reader #(
        .NB_DATA    (NB_DATA),
        .N_ADDRESS  (N_ADDRESS),
        .NB_ADDRESS (NB_ADDRESS),
        .NB_BYTE    (NB_BYTE)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .o_r_addr   (o_r_addr),
        .o_r_en     (o_r_en),
        .i_r_data   (i_r_data),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 i_clk = ~i_clk;

    int cycle = 0;
    always @(posedge i_clk) cycle <= cycle + 1;

    int c0       = 0;   // value of cycle just after the edge that saw i_start
    int n_cmp    = 0;
    int n_err    = 0;
    int done_cnt = 0;
    int done_rel = -1;
    logic [NB_BYTE-1:0] exp_q [$];

    // Cycle number relative to the start edge: cycle 1 follows that edge.
    function automatic int rel();
        return cycle - c0 + 1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the whole dump is the optional header followed by
    // every word of the image, least significant byte first.
    task automatic push_expected();
`ifdef MEM_DUMP_HEADER_EN
        exp_q.push_back(8'hA5);
        exp_q.push_back(NB_BYTE'(N_ADDRESS));
`endif
        for (int a = 0; a < N_ADDRESS; a++)
            for (int b = 0; b < N_BYTES; b++)
                exp_q.push_back(NB_BYTE'(mem[a] >> (8 * b)));
    endtask

    // Monitor: sample mid-cycle, commit the handshake at the next rising edge.
    initial begin : monitor
        logic               pend;
        logic [NB_BYTE-1:0] d;
        forever begin
            @(negedge i_clk);
            pend = o_tx_valid && i_tx_ready && !i_rst;
            d    = o_tx_data;
            if (o_done === 1'b1 && !i_rst) begin
                done_cnt++;
                done_rel = rel();
            end
            @(posedge i_clk);
            if (pend && !i_rst) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL stray_byte: got %0h, expected no byte (t=%0t)", d, $time);
                end else begin
                    check("stream_byte", d, exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic at_cycle(input int n);
        while (rel() < n) step();
    endtask

    task automatic start_dump();
        push_expected();
        done_cnt = 0;
        done_rel = -1;
        step();
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        c0 = cycle;
    endtask

    // Runs until o_done, optionally with random backpressure and stray start
    // pulses while busy. Returns the relative cycle in which o_done was seen.
    task automatic wait_done(input int budget, input bit rnd, output int dcyc);
        int n;
        n    = 0;
        dcyc = -1;
        forever begin
            if (o_done) begin
                dcyc = rel();
                break;
            end
            if (n >= budget) begin
                n_cmp++;
                n_err++;
                $display("FAIL done_timeout: got no o_done, expected one within %0d cycles", budget);
                break;
            end
            if (rnd) begin
                i_tx_ready = ($urandom_range(0, 2) != 0);
                i_start    = o_busy && ($urandom_range(0, 7) == 0);
            end
            step();
            n++;
        end
        i_start = 1'b0;
    endtask

    // Common tail of every dump: one cycle into IDLE, all bytes consumed.
    task automatic finish_checks(input string tag);
        step();
        check({tag, "_busy_after_done"}, o_busy, 1'b0);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_bytes_left"}, exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int dcyc;
        int idle_valid;

        // ---------------- reset state and idle behaviour ----------------
        #3;
        check("reset_outputs", {o_r_addr, o_r_en, o_tx_data, o_tx_valid, o_busy, o_done}, '0);
        @(negedge i_clk);
        i_rst = 1'b0;
        idle_valid = 0;
        for (int i = 0; i < 8; i++) begin
            i_tx_ready = ~i_tx_ready;
            step();
            if (o_tx_valid) idle_valid++;
        end
        check("idle_valid_cycles", idle_valid, 0);
        check("idle_busy", o_busy, 1'b0);

        // ---------------- single word timing + full dump ----------------
        for (int i = 0; i < N_ADDRESS; i++) mem[i] = NB_DATA'(i);
        mem[0] = 32'h11223344;
        i_tx_ready = 1'b1;
        start_dump();
`ifdef MEM_DUMP_HEADER_EN
        check("hdr_magic", o_tx_data, 8'hA5);
        at_cycle(2);
        check("hdr_count", o_tx_data, NB_BYTE'(N_ADDRESS));
`endif
        at_cycle(1 + H);
        check("read_en", o_r_en, 1'b1);
        check("read_addr", o_r_addr, 0);
        check("read_busy", o_busy, 1'b1);
        check("read_no_valid", o_tx_valid, 1'b0);
        at_cycle(2 + H);
        check("send_en_low", o_r_en, 1'b0);
        check("send_valid", o_tx_valid, 1'b1);
        check("send_byte0", o_tx_data, 8'h44);
        at_cycle(5 + H);
        check("send_byte3", o_tx_data, 8'h11);
        at_cycle(6 + H);
        check("word1_addr", o_r_addr, 1);
        wait_done(2 * DONE_CYC, 1'b0, dcyc);
        check("full_done_cycle", dcyc, DONE_CYC);
        check("full_last_addr", o_r_addr, N_ADDRESS - 1);
        finish_checks("full");
        check("full_monitor_done_cycle", done_rel, DONE_CYC);

        // ---------------- backpressure on byte 1 ----------------
        mem[0] = 32'hDEADBEEF;
        start_dump();
        at_cycle(3 + H);
        i_tx_ready = 1'b0;
        check("bp_hold_c3", {o_tx_valid, o_tx_data}, {1'b1, 8'hBE});
        at_cycle(4 + H);
        check("bp_hold_c4", {o_tx_valid, o_tx_data}, {1'b1, 8'hBE});
        at_cycle(5 + H);
        check("bp_hold_c5", {o_tx_valid, o_tx_data}, {1'b1, 8'hBE});
        at_cycle(6 + H);
        i_tx_ready = 1'b1;
        check("bp_accept", {o_tx_valid, o_tx_data}, {1'b1, 8'hBE});
        at_cycle(7 + H);
        check("bp_next", o_tx_data, 8'hAD);
        wait_done(2 * DONE_CYC, 1'b0, dcyc);
        check("bp_done_cycle", dcyc, DONE_CYC + 3);
        finish_checks("bp");

        // ---------------- start while busy, then reset mid-SEND ----------------
        mem[0] = 32'h11223344;
        start_dump();
        at_cycle(10);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        at_cycle(12);
        #2;
        i_rst = 1'b1;
        #1;
        check("midrst_outputs", {o_r_addr, o_r_en, o_tx_data, o_tx_valid, o_busy, o_done}, '0);
        exp_q.delete();
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        start_dump();
        at_cycle(1 + H);
        check("restart_addr", {o_r_en, o_r_addr}, {1'b1, NB_ADDRESS'(0)});
        at_cycle(2 + H);
        check("restart_byte0", o_tx_data, 8'h44);
        wait_done(2 * DONE_CYC, 1'b0, dcyc);
        check("restart_done_cycle", dcyc, DONE_CYC);
        finish_checks("restart");

        // ---------------- random images with random backpressure ----------------
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < N_ADDRESS; i++) mem[i] = $urandom;
            i_tx_ready = 1'b1;
            start_dump();
            wait_done(20 * DONE_CYC, 1'b1, dcyc);
            i_tx_ready = 1'b1;
            finish_checks("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_dump_reader.md
Name: mem_dump_reader

Overview:
- Reads the data memory sequentially, address 0 to N_ADDRESS-1, through its async read port.
- Serializes each word into bytes on a valid/ready byte stream feeding the debug UART transmitter.
- Sits between the memory read port and the debug unit's TX path, so memory contents can be shipped to the host after program halt.

Parameters:
- NB_DATA, 32, memory word width; must be a multiple of 8.
- N_ADDRESS, 64, number of words to dump (whole memory).
- NB_ADDRESS, $clog2(N_ADDRESS), address width.
- NB_BYTE, 8, stream byte width.

Ports:
- i_clk  input  1  clock, all state on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_start  input  1  start pulse; sampled only in IDLE.
- o_r_addr  output  NB_ADDRESS  memory read address.
- o_r_en  output  1  memory read enable.
- i_r_data  input  NB_DATA  memory read data; combinational from o_r_addr, valid in the same cycle.
- o_tx_data  output  NB_BYTE  stream byte.
- o_tx_valid  output  1  stream byte valid.
- i_tx_ready  input  1  downstream accepts byte.
- o_busy  output  1  high in every state except IDLE.
- o_done  output  1  one-cycle pulse when dump completes.

Behaviour:
- Reset (async, immediate): state IDLE.
  - Address counter and byte counter are 0; word register is 0.
  - All outputs are 0: o_r_addr, o_r_en, o_tx_data, o_tx_valid, o_busy, o_done.
- States: IDLE, READ, SEND, DONE (plus HDR with the optional feature).
- IDLE: i_start=1 at an edge sets addr=0 and goes to READ.
- READ (exactly 1 cycle):
  - o_r_en=1 and o_r_addr=addr.
  - At the edge, i_r_data is latched into the word register, byte_cnt=0, go to SEND.
  - o_r_en=0 in all other states; o_r_addr holds its last value.
- SEND:
  - o_tx_valid=1; o_tx_data = word[byte_cnt*8 +: 8], LSB byte first.
  - Transfer occurs on an edge with o_tx_valid && i_tx_ready.
  - On transfer with byte_cnt < NB_DATA/8-1: byte_cnt++.
  - On transfer with the last byte and addr < N_ADDRESS-1: addr++, go to READ.
  - On transfer with the last byte and addr == N_ADDRESS-1: go to DONE.
  - Without a transfer, o_tx_data and o_tx_valid hold stable; no byte is ever dropped or duplicated.
- DONE: o_done=1 for 1 cycle, then IDLE. o_busy=1 in READ/SEND/DONE/HDR.
- Timing with i_tx_ready tied high, i_start seen at edge E0:
  - Word k is READ in cycle 5k+1.
  - Its bytes are in SEND during cycles 5k+2..5k+5.
  - DONE is cycle 5*N_ADDRESS+1.
- i_start while busy: ignored, no restart.
- i_tx_ready while o_tx_valid=0: ignored.
- Address wrap: the counter never wraps; the dump ends at N_ADDRESS-1.
- Reset mid-operation: o_tx_valid drops asynchronously and any partial word is discarded. The next i_start restarts at address 0.

Optional Feature:
- Macro MEM_DUMP_HEADER_EN.
- When defined: IDLE+i_start goes to HDR instead of READ.
  - HDR drives o_tx_valid=1 with o_tx_data=8'hA5, then 8'(N_ADDRESS), over 2 handshaked transfers, then READ at addr 0.
  - All word timing shifts by the header transfer cycles.
- When undefined: there is no HDR state, and the first streamed byte is byte 0 of mem[0].

Test Plan:
- Reset: assert i_rst mid-cycle -> all outputs 0 immediately, o_busy=0; i_tx_ready toggling while idle produces no valid.
- Single word: mem[0]=32'h11223344, ready=1, start pulse -> cycle1 o_r_en=1, o_r_addr=0; cycles 2-5 bytes 44,33,22,11 with valid=1.
- Full dump: mem[i]=i, ready=1 -> 256 bytes, the k-th word emitted as {k,00,00,00}; o_done pulses in cycle 321 only; o_busy falls cycle 322.
- Backpressure: ready=0 for 3 cycles while byte 1 of mem[0]=32'hDEADBEEF is presented -> BE held valid for 3 cycles, then accepted; following bytes AD, DE in order, no duplicates.
- Start while busy / reset mid-SEND: second start at cycle 10 ignored, byte sequence unchanged. Reset at cycle 12 -> valid drops that cycle; a new start dumps again from address 0 byte 0.
- MEM_DUMP_HEADER_EN defined, ready=1 -> first bytes A5, 40, then 44 (mem[0]=32'h11223344); o_done in cycle 323.
